// File: rtl/wm8731_i2c_responder.sv
// WM8731 control-port I2C target: decodes 3-byte register writes into a shadow
// copy of the codec register file, ACKing/NACKing the way the real codec does.
module wm8731_i2c_responder #(
  parameter logic [6:0]  DEV_ADDR    = 7'h1A,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oen,
  input  logic [3:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_wr_valid,
  output logic [6:0] o_wr_addr,
  output logic [8:0] o_wr_data,
  output logic       o_bad_reg,
  output logic       o_busy,
  output logic [7:0] o_wr_cnt
);
  localparam int unsigned NUM_REGS = 10;
  localparam int unsigned AW       = 7;
  localparam int unsigned DW       = 9;
  localparam int unsigned CW       = 8;
  localparam logic [AW-1:0] RESET_REG = AW'(15);

  typedef enum logic [2:0] {
    S_IDLE, S_DEV, S_ACK_DEV, S_B1, S_ACK1, S_B2, S_ACK2, S_IGNORE
  } state_e;

  function automatic logic [DW-1:0] reg_default(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1: return 9'h097;
      4'd2, 4'd3: return 9'h079;
      4'd4:       return 9'h00A;
      4'd5:       return 9'h008;
      4'd6:       return 9'h09F;
      4'd7:       return 9'h00A;
      default:    return '0;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, sda_prev_q;
  state_e                 state_q, state_d, ack_next_c;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [6:0]             shreg_q, shreg_d;
  logic                   ack_q, ack_d, ack_phase_q, ack_phase_d;
  logic [AW-1:0]          reg_addr_q, reg_addr_d;
  logic                   d8_q, d8_d;
  logic                   sda_oen_q, sda_oen_d, busy_q, busy_d;
  logic                   wr_valid_q, wr_valid_d, bad_reg_q, bad_reg_d;
  logic [AW-1:0]          wr_addr_q, wr_addr_d;
  logic [DW-1:0]          wr_data_q, wr_data_d;
  logic [CW-1:0]          wr_cnt_q, wr_cnt_d;
  logic [DW-1:0]          shadow_q [NUM_REGS];
  logic [DW-1:0]          shadow_d [NUM_REGS];
  logic                   scl_s, sda_s, start_c, stop_c, scl_rise_c, scl_fall_c;
  logic [7:0]             byte_c;
  logic [DW-1:0]          rd_data_c;

  assign scl_s      = scl_sync_q[SYNC_STAGES-1];
  assign sda_s      = sda_sync_q[SYNC_STAGES-1];
  assign start_c    = scl_s && scl_prev_q && sda_prev_q && !sda_s;
  assign stop_c     = scl_s && scl_prev_q && !sda_prev_q && sda_s;
  assign scl_rise_c = scl_s && !scl_prev_q;
  assign scl_fall_c = !scl_s && scl_prev_q;
  assign byte_c     = {shreg_q, sda_s};

  // Where to go once the 9th (ACK) clock has finished.
  always_comb begin
    ack_next_c = S_IGNORE;
    case (state_q)
      S_ACK_DEV: ack_next_c = ack_q ? S_B1 : S_IGNORE;
      S_ACK1:    ack_next_c = S_B2;
      default:   ack_next_c = S_IGNORE;
    endcase
  end

  always_comb begin
    scl_sync_d  = {scl_sync_q[SYNC_STAGES-2:0], i_scl};
    sda_sync_d  = {sda_sync_q[SYNC_STAGES-2:0], i_sda};
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    ack_d       = ack_q;
    ack_phase_d = ack_phase_q;
    reg_addr_d  = reg_addr_q;
    d8_d        = d8_q;
    sda_oen_d   = sda_oen_q;
    busy_d      = busy_q;
    wr_valid_d  = 1'b0;
    bad_reg_d   = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_cnt_d    = wr_cnt_q;
    shadow_d    = shadow_q;

    if (stop_c) begin
      state_d     = S_IDLE;
      busy_d      = 1'b0;
      sda_oen_d   = 1'b0;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
    end else if (start_c) begin
      state_d     = S_DEV;
      busy_d      = 1'b1;
      sda_oen_d   = 1'b0;
      bit_cnt_d   = '0;
      ack_phase_d = 1'b0;
    end else begin
      if (scl_rise_c && (state_q == S_DEV || state_q == S_B1 || state_q == S_B2)) begin
        shreg_d   = byte_c[6:0];
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      case (state_q)
        S_DEV: if (scl_rise_c && bit_cnt_q == 3'd7) begin
          ack_d       = (byte_c[7:1] == DEV_ADDR) && !byte_c[0];
          ack_phase_d = 1'b0;
          state_d     = S_ACK_DEV;
        end
        S_B1: if (scl_rise_c && bit_cnt_q == 3'd7) begin
          reg_addr_d  = byte_c[7:1];
          d8_d        = byte_c[0];
          ack_d       = 1'b1;
          ack_phase_d = 1'b0;
          state_d     = S_ACK1;
        end
        S_B2: if (scl_rise_c && bit_cnt_q == 3'd7) begin
          ack_d       = 1'b1;
          ack_phase_d = 1'b0;
          state_d     = S_ACK2;
          wr_valid_d  = 1'b1;
          wr_addr_d   = reg_addr_q;
          wr_data_d   = {d8_q, byte_c};
          if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CW'(1);
          if (reg_addr_q < AW'(NUM_REGS)) begin
            for (int unsigned i = 0; i < NUM_REGS; i++)
              if (reg_addr_q == AW'(i)) shadow_d[i] = {d8_q, byte_c};
          end else if (reg_addr_q == RESET_REG) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) shadow_d[i] = reg_default(4'(i));
          end else begin
            bad_reg_d = 1'b1;
          end
        end
        // First SCL fall drives the ACK bit, the second ends the 9th clock.
        S_ACK_DEV, S_ACK1, S_ACK2: if (scl_fall_c) begin
          if (!ack_phase_q) begin
            ack_phase_d = 1'b1;
            sda_oen_d   = ack_q;
          end else begin
            ack_phase_d = 1'b0;
            sda_oen_d   = 1'b0;
            bit_cnt_d   = '0;
            state_d     = ack_next_c;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_sync_q  <= '1;
      sda_sync_q  <= '1;
      scl_prev_q  <= 1'b1;
      sda_prev_q  <= 1'b1;
      state_q     <= S_IDLE;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      ack_q       <= 1'b0;
      ack_phase_q <= 1'b0;
      reg_addr_q  <= '0;
      d8_q        <= 1'b0;
      sda_oen_q   <= 1'b0;
      busy_q      <= 1'b0;
      wr_valid_q  <= 1'b0;
      bad_reg_q   <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_cnt_q    <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) shadow_q[i] <= reg_default(4'(i));
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_s;
      sda_prev_q  <= sda_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ack_q       <= ack_d;
      ack_phase_q <= ack_phase_d;
      reg_addr_q  <= reg_addr_d;
      d8_q        <= d8_d;
      sda_oen_q   <= sda_oen_d;
      busy_q      <= busy_d;
      wr_valid_q  <= wr_valid_d;
      bad_reg_q   <= bad_reg_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      wr_cnt_q    <= wr_cnt_d;
      shadow_q    <= shadow_d;
    end
  end

  // Zero-latency shadow read; unimplemented indices read as zero.
  always_comb begin
    rd_data_c = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (i_rd_addr == 4'(i)) rd_data_c = shadow_q[i];
  end

  assign o_rd_data  = rd_data_c;
  assign o_sda_oen  = sda_oen_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_bad_reg  = bad_reg_q;
  assign o_busy     = busy_q;
  assign o_wr_cnt   = wr_cnt_q;
endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Directed bench for wm8731_i2c_responder: table of I2C transfers with
// hand-computed results, plus repeated-START and mid-transfer reset sequences.
module tb_wm8731_i2c_responder;
  localparam int unsigned Q = 8;

  logic       i_clk = 1'b0;
  logic       i_rst_n, i_scl, sda_drv, i_sda;
  logic       o_sda_oen, o_wr_valid, o_bad_reg, o_busy;
  logic [3:0] i_rd_addr;
  logic [8:0] o_rd_data, o_wr_data;
  logic [6:0] o_wr_addr;
  logic [7:0] o_wr_cnt;

  assign i_sda = sda_drv & ~o_sda_oen;
  always #5 i_clk = ~i_clk;

  wm8731_i2c_responder dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_scl(i_scl), .i_sda(i_sda),
    .o_sda_oen(o_sda_oen), .i_rd_addr(i_rd_addr), .o_rd_data(o_rd_data),
    .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_bad_reg(o_bad_reg), .o_busy(o_busy), .o_wr_cnt(o_wr_cnt)
  );

  typedef struct {
    string       name;
    logic [31:0] bytes;
    int          n;
    logic [3:0]  acks;
    int          nvalid;
    int          nbad;
    int          upd;
    logic [3:0]  widx;
    logic [8:0]  wdat;
  } xv_t;

  xv_t        vec [7];
  logic [8:0] dflt [16] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A, 9'h008, 9'h09F, 9'h00A,
                            9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000, 9'h000};
  logic [8:0] exp_sh [16];
  logic [7:0] exp_cnt;
  logic [6:0] exp_addr;
  logic [8:0] exp_data;
  int errors = 0, checks = 0;
  int n_valid = 0, n_bad = 0, n_both = 0, data_drive = 0;

  always @(posedge i_clk) begin
    if (o_wr_valid) n_valid++;
    if (o_bad_reg) n_bad++;
    if (o_wr_valid && o_bad_reg) n_both++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n * Q) @(negedge i_clk);
  endtask

  task automatic i2c_start();
    sda_drv = 1'b0; wait_q(1); i_scl = 1'b0; wait_q(1);
  endtask

  task automatic i2c_rstart();
    sda_drv = 1'b1; wait_q(1); i_scl = 1'b1; wait_q(1); i2c_start();
  endtask

  task automatic i2c_stop();
    sda_drv = 1'b0; wait_q(1); i_scl = 1'b1; wait_q(1); sda_drv = 1'b1; wait_q(1);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int j = 7; j >= 0; j--) begin
      sda_drv = b[j];
      wait_q(1); i_scl = 1'b1; wait_q(1);
      if (o_sda_oen) data_drive++;
      wait_q(1); i_scl = 1'b0; wait_q(1);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b);
    sda_drv = 1'b1; wait_q(1); i_scl = 1'b1; wait_q(1);
    ack = o_sda_oen;
    wait_q(1); i_scl = 1'b0; wait_q(1);
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      i_rd_addr = 4'(i);
      #1;
      chk($sformatf("%s_rd%0d", tag, i), 32'(o_rd_data), 32'(exp_sh[i]));
    end
  endtask

  task automatic set_vec(input int k, input string name, input logic [31:0] bytes, input int n,
                         input logic [3:0] acks, input int nvalid, input int nbad, input int upd,
                         input logic [3:0] widx, input logic [8:0] wdat);
    vec[k].name = name;   vec[k].bytes = bytes;   vec[k].n = n;     vec[k].acks = acks;
    vec[k].nvalid = nvalid; vec[k].nbad = nbad;   vec[k].upd = upd;
    vec[k].widx = widx;   vec[k].wdat = wdat;
  endtask

  task automatic reset_model();
    for (int i = 0; i < 16; i++) exp_sh[i] = dflt[i];
    exp_cnt = '0; exp_addr = '0; exp_data = '0;
  endtask

  task automatic run_vec(input int k);
    xv_t        v;
    logic [3:0] acks;
    logic       a;
    int         v0, b0, bo0, dd0;
    v = vec[k];
    v0 = n_valid; b0 = n_bad; bo0 = n_both; dd0 = data_drive; acks = '0;
    i2c_start();
    chk({v.name, "_busy"}, 32'(o_busy), 32'd1);
    for (int j = 0; j < v.n; j++) begin
      send_byte(v.bytes[31-8*j -: 8], a);
      acks[j] = a;
    end
    i2c_stop();
    wait_q(1);
    if (v.nvalid != 0) begin
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      exp_addr = 7'(v.widx);
      exp_data = v.wdat;
    end
    if (v.upd == 1) exp_sh[v.widx] = v.wdat;
    if (v.upd == 2) for (int i = 0; i < 16; i++) exp_sh[i] = dflt[i];
    chk({v.name, "_acks"},   32'(acks), 32'(v.acks));
    chk({v.name, "_valid"},  32'(n_valid - v0), 32'(v.nvalid));
    chk({v.name, "_bad"},    32'(n_bad - b0), 32'(v.nbad));
    chk({v.name, "_both"},   32'(n_both - bo0), 32'(v.nbad));
    chk({v.name, "_drive"},  32'(data_drive - dd0), 32'd0);
    chk({v.name, "_idle"},   32'(o_busy), 32'd0);
    chk({v.name, "_waddr"},  32'(o_wr_addr), 32'(exp_addr));
    chk({v.name, "_wdata"},  32'(o_wr_data), 32'(exp_data));
    chk({v.name, "_cnt"},    32'(o_wr_cnt), 32'(exp_cnt));
    check_regs(v.name);
  endtask

  initial begin
    logic       a;
    logic [4:0] racks;
    int         v0;

    set_vec(0, "wr_r4",     32'h34081500, 3, 4'b0111, 1, 0, 1, 4'd4,  9'h015);
    set_vec(1, "bad_dev",   32'h36081500, 3, 4'b0000, 0, 0, 0, 4'd0,  9'h000);
    set_vec(2, "read_bit",  32'h35081500, 3, 4'b0000, 0, 0, 0, 4'd0,  9'h000);
    set_vec(3, "wr_r4b",    32'h34081500, 3, 4'b0111, 1, 0, 1, 4'd4,  9'h015);
    set_vec(4, "reset_reg", 32'h341E0000, 3, 4'b0111, 1, 0, 2, 4'd15, 9'h000);
    set_vec(5, "bad_reg",   32'h3416FFAA, 4, 4'b0111, 1, 1, 0, 4'd11, 9'h0FF);
    set_vec(6, "wr_r5",     32'h340A5500, 3, 4'b0111, 1, 0, 1, 4'd5,  9'h055);

    i_rst_n = 1'b0; i_scl = 1'b1; sda_drv = 1'b1; i_rd_addr = '0;
    reset_model();
    repeat (4) @(negedge i_clk);
    chk("rst_oen",   32'(o_sda_oen),  32'd0);
    chk("rst_valid", 32'(o_wr_valid), 32'd0);
    chk("rst_bad",   32'(o_bad_reg),  32'd0);
    chk("rst_busy",  32'(o_busy),     32'd0);
    chk("rst_waddr", 32'(o_wr_addr),  32'd0);
    chk("rst_wdata", 32'(o_wr_data),  32'd0);
    chk("rst_cnt",   32'(o_wr_cnt),   32'd0);
    i_rst_n = 1'b1;
    repeat (4) @(negedge i_clk);
    check_regs("reset");

    for (int k = 0; k < 7; k++) run_vec(k);

    // Partial write (reg 6) abandoned by a repeated START, then a write of 001 to reg 9.
    v0 = n_valid;
    i2c_start();
    send_byte(8'h34, a); racks[0] = a;
    send_byte(8'h0C, a); racks[1] = a;
    i2c_rstart();
    send_byte(8'h34, a); racks[2] = a;
    send_byte(8'h12, a); racks[3] = a;
    send_byte(8'h01, a); racks[4] = a;
    i2c_stop();
    wait_q(1);
    exp_sh[9] = 9'h001;
    exp_cnt = exp_cnt + 8'd1;
    chk("rs_acks",  32'(racks), 32'h1F);
    chk("rs_valid", 32'(n_valid - v0), 32'd1);
    chk("rs_waddr", 32'(o_wr_addr), 32'h09);
    chk("rs_wdata", 32'(o_wr_data), 32'h001);
    chk("rs_cnt",   32'(o_wr_cnt), 32'(exp_cnt));
    check_regs("rs");

    // Reset while the responder is driving the ACK of the register byte.
    i2c_start();
    send_byte(8'h34, a);
    chk("ar_ack0", 32'(a), 32'd1);
    send_bits(8'h0E);
    chk("ar_oen_pre", 32'(o_sda_oen), 32'd1);
    i_rd_addr = 4'd5;
    #1;
    chk("ar_r5_pre", 32'(o_rd_data), 32'h055);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    chk("ar_oen",   32'(o_sda_oen), 32'd0);
    chk("ar_busy",  32'(o_busy),    32'd0);
    chk("ar_cnt",   32'(o_wr_cnt),  32'd0);
    chk("ar_waddr", 32'(o_wr_addr), 32'd0);
    chk("ar_r5",    32'(o_rd_data), 32'h008);
    i_scl = 1'b1; wait_q(1); sda_drv = 1'b1; wait_q(1);
    i_rst_n = 1'b1;
    wait_q(1);
    reset_model();
    check_regs("ar");
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
